pos_cmd_sequencer: RTL and testbench

Upstream feeder for the motor control stage. Assembles 16-bit target positions from a byte stream delivered by the host link receiver, buffers them in a FIFO, and generates the 4.096 ms system tick. On each tick it issues the next buffered position as a one-cycle `newPos`/`newPosSignal` command, plus the `clock_4ms` strobe the motor stage consumes.

---
 rtl/pos_cmd_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_pos_cmd_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pos_cmd_sequencer.sv
// Position command sequencer: byte-pair word assembler, position FIFO and 4.096 ms tick/pop generator.
// Optional build macro POS_CMD_CLAMP_EN clamps assembled words to MAX_POS and drives clamp_hit.
module pos_cmd_sequencer #(
    parameter int          TICK_DIV        = 40960,
    parameter int          FIFO_DEPTH_LOG2 = 4,
    parameter int          BYTE_TIMEOUT    = 10000,
    parameter logic [15:0] MAX_POS         = 16'hFFFF
) (
    input  logic                       CLK_10MHZ,
    input  logic                       RST_N,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    input  logic                       clr_flags,
    output logic                       clock_4ms,
    output logic [15:0]                newPos,
    output logic                       newPosSignal,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_level,
    output logic                       overflow,
    output logic                       underrun,
    output logic                       clamp_hit
);

    localparam int PTR_W  = FIFO_DEPTH_LOG2;
    localparam int LVL_W  = FIFO_DEPTH_LOG2 + 1;
    localparam int DEPTH  = 1 << FIFO_DEPTH_LOG2;
    localparam int TCNT_W = $clog2(BYTE_TIMEOUT + 1);
    localparam int TICK_W = $clog2(TICK_DIV);

    localparam logic [TCNT_W-1:0] TOUT_MAX  = TCNT_W'(BYTE_TIMEOUT);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(DEPTH);

    function automatic logic [15:0] clamp_pos(input logic [15:0] w);
        return (w > MAX_POS) ? MAX_POS : w;
    endfunction

    typedef enum logic {WAIT_HI, WAIT_LO} asm_state_t;

    asm_state_t        asm_state;
    logic [7:0]        hi_byte;
    logic [TCNT_W-1:0] tout_cnt;
    logic [TICK_W-1:0] tick_cnt;
    logic              armed;

    logic [15:0]       fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic              push;
    logic              pop;
    logic              tick_edge;
    logic              fifo_full;
    logic              accept;
    logic              drop;
    logic [15:0]       word_raw;
    logic [15:0]       word_p0;

    // Stage p0: combinational word formation and push/pop arbitration
    assign push      = (asm_state == WAIT_LO) && rx_valid;
    assign word_raw  = {hi_byte, rx_data};
    assign tick_edge = (tick_cnt == TICK_LAST);
    assign pop       = tick_edge && (fifo_level != '0);
    assign fifo_full = (fifo_level == LVL_FULL);
    // A full FIFO still takes a word when the same edge frees a slot.
    assign accept    = push && (!fifo_full || pop);
    assign drop      = push && fifo_full && !pop;

`ifdef POS_CMD_CLAMP_EN
    logic clamp_flag;
    logic clamp_hit_r;

    assign word_p0    = clamp_pos(word_raw);
    assign clamp_flag = push && (word_raw > MAX_POS);
    assign clamp_hit  = clamp_hit_r;

    always_ff @(posedge CLK_10MHZ or negedge RST_N) begin
        if (!RST_N) begin
            clamp_hit_r <= 1'b0;
        end else if (clamp_flag) begin
            clamp_hit_r <= 1'b1;
        end else if (clr_flags) begin
            clamp_hit_r <= 1'b0;
        end
    end
`else
    assign word_p0   = word_raw;
    assign clamp_hit = 1'b0;
`endif

    always_ff @(posedge CLK_10MHZ or negedge RST_N) begin
        if (!RST_N) begin
            asm_state <= WAIT_HI;
            hi_byte   <= 8'h00;
            tout_cnt  <= '0;
        end else begin
            case (asm_state)
                WAIT_HI: begin
                    if (rx_valid) begin
                        hi_byte   <= rx_data;
                        tout_cnt  <= '0;
                        asm_state <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (rx_valid) begin
                        asm_state <= WAIT_HI;
                    end else if (tout_cnt == TOUT_MAX) begin
                        asm_state <= WAIT_HI;
                    end else begin
                        tout_cnt <= tout_cnt + TCNT_W'(1);
                    end
                end
                default: asm_state <= WAIT_HI;
            endcase
        end
    end

    always_ff @(posedge CLK_10MHZ or negedge RST_N) begin
        if (!RST_N) begin
            tick_cnt  <= '0;
            clock_4ms <= 1'b0;
        end else begin
            clock_4ms <= tick_edge;
            tick_cnt  <= tick_edge ? '0 : tick_cnt + TICK_W'(1);
        end
    end

    // FIFO storage carries no reset; emptiness is tracked by the level/pointers.
    always_ff @(posedge CLK_10MHZ) begin
        if (accept) begin
            fifo_mem[wr_ptr] <= word_p0;
        end
    end

    // Stage p1: registered FIFO control and position command outputs
    always_ff @(posedge CLK_10MHZ or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            newPos       <= 16'h0000;
            newPosSignal <= 1'b0;
        end else begin
            newPosSignal <= pop;
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                newPos <= fifo_mem[rd_ptr];
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({accept, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Set events take priority over clr_flags on the same edge.
    always_ff @(posedge CLK_10MHZ or negedge RST_N) begin
        if (!RST_N) begin
            armed    <= 1'b0;
            overflow <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (pop) begin
                armed <= 1'b1;
            end else if (clr_flags) begin
                armed <= 1'b0;
            end

            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_flags) begin
                overflow <= 1'b0;
            end

            if (tick_edge && (fifo_level == '0) && armed) begin
                underrun <= 1'b1;
            end else if (clr_flags) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pos_cmd_sequencer.sv
// Directed bench for pos_cmd_sequencer: tick cadence, word assembly, FIFO order/overflow, timeout, flags, reset.
module tb_pos_cmd_sequencer;

    localparam int          TD   = 100;
    localparam int          LOG2 = 4;
    localparam int          BT   = 20;
    localparam logic [15:0] MP   = 16'd1000;

    logic              CLK_10MHZ = 1'b0;
    logic              RST_N     = 1'b0;
    logic [7:0]        rx_data   = 8'h00;
    logic              rx_valid  = 1'b0;
    logic              clr_flags = 1'b0;
    logic              clock_4ms;
    logic [15:0]       newPos;
    logic              newPosSignal;
    logic [LOG2:0]     fifo_level;
    logic              overflow;
    logic              underrun;
    logic              clamp_hit;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    pos_cmd_sequencer #(
        .TICK_DIV(TD),
        .FIFO_DEPTH_LOG2(LOG2),
        .BYTE_TIMEOUT(BT),
        .MAX_POS(MP)
    ) dut (
        .CLK_10MHZ(CLK_10MHZ),
        .RST_N(RST_N),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .clr_flags(clr_flags),
        .clock_4ms(clock_4ms),
        .newPos(newPos),
        .newPosSignal(newPosSignal),
        .fifo_level(fifo_level),
        .overflow(overflow),
        .underrun(underrun),
        .clamp_hit(clamp_hit)
    );

    always #5 CLK_10MHZ = ~CLK_10MHZ;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK_10MHZ);
        #1;
        cyc++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic pulse_clr();
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            step();
            n++;
            if (clock_4ms !== 1'b1) chk("sig_outside_tick", 32'(newPosSignal), 32'd0);
        end while (clock_4ms !== 1'b1 && n < 3 * TD);
        chk("tick_found", 32'(clock_4ms), 32'd1);
        chk("tick_phase", 32'(cyc % TD), 32'd0);
    endtask

    initial begin
        logic [15:0] clamp_exp;
        logic        clamp_flag_exp;

        // Reset state
        repeat (3) @(posedge CLK_10MHZ);
        #1;
        chk("rst_clock_4ms", 32'(clock_4ms), 32'd0);
        chk("rst_newPos", 32'(newPos), 32'd0);
        chk("rst_sig", 32'(newPosSignal), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_flags", {29'd0, overflow, underrun, clamp_hit}, 32'd0);
        RST_N = 1'b1;
        cyc   = 0;

        // Idle ticks at cycles 100, 200, 300 with nothing queued and not armed
        for (int k = 1; k <= 3 * TD; k++) begin
            step();
            chk("idle_tick", 32'(clock_4ms), (k % TD == 0) ? 32'd1 : 32'd0);
            chk("idle_sig", 32'(newPosSignal), 32'd0);
            chk("idle_underrun", 32'(underrun), 32'd0);
        end

        // Two words, popped in order on successive ticks, then underrun
        send_word(16'h1234);
        send_word(16'hABCD);
        chk("two_words_level", 32'(fifo_level), 32'd2);
        wait_tick();
        chk("pop1_pos", 32'(newPos), 32'h1234);
        chk("pop1_sig", 32'(newPosSignal), 32'd1);
        chk("pop1_level", 32'(fifo_level), 32'd1);
        wait_tick();
        chk("pop2_pos", 32'(newPos), 32'hABCD);
        chk("pop2_sig", 32'(newPosSignal), 32'd1);
        chk("pop2_level", 32'(fifo_level), 32'd0);
        chk("pop2_underrun", 32'(underrun), 32'd0);
        wait_tick();
        chk("empty_sig", 32'(newPosSignal), 32'd0);
        chk("empty_pos_hold", 32'(newPos), 32'hABCD);
        chk("empty_underrun", 32'(underrun), 32'd1);
        pulse_clr();
        chk("clr_underrun", 32'(underrun), 32'd0);
        wait_tick();
        chk("disarmed_underrun", 32'(underrun), 32'd0);
        chk("disarmed_sig", 32'(newPosSignal), 32'd0);

        // High byte abandoned after timeout; next pair forms a word
        send_byte(8'h55);
        repeat (BT + 5) step();
        send_word(16'h0102);
        chk("timeout_level", 32'(fifo_level), 32'd1);
        wait_tick();
        chk("timeout_pos", 32'(newPos), 32'h0102);
        chk("timeout_sig", 32'(newPosSignal), 32'd1);
        chk("timeout_level_after", 32'(fifo_level), 32'd0);

        // Overflow: 17 pushes into a depth-16 FIFO
        for (int i = 0; i < 17; i++) send_word(16'h1000 + 16'(i));
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_level", 32'(fifo_level), 32'd16);
        pulse_clr();
        chk("ovf_clr", 32'(overflow), 32'd0);
        while (cyc % TD != TD - 2) step();
        send_byte(8'h22);
        send_byte(8'h22);
        chk("fullpush_tick", 32'(clock_4ms), 32'd1);
        chk("fullpush_sig", 32'(newPosSignal), 32'd1);
        chk("fullpush_pos", 32'(newPos), 32'h1000);
        chk("fullpush_level", 32'(fifo_level), 32'd16);
        chk("fullpush_no_ovf", 32'(overflow), 32'd0);
        for (int i = 1; i < 16; i++) begin
            wait_tick();
            chk("drain_pos", 32'(newPos), 32'h1000 + 32'(i));
            chk("drain_sig", 32'(newPosSignal), 32'd1);
        end
        wait_tick();
        chk("drain_last_pos", 32'(newPos), 32'h2222);
        chk("drain_last_level", 32'(fifo_level), 32'd0);
        wait_tick();
        chk("drain_underrun", 32'(underrun), 32'd1);
        chk("drain_empty_sig", 32'(newPosSignal), 32'd0);

        // Word above MAX_POS
`ifdef POS_CMD_CLAMP_EN
        clamp_exp      = MP;
        clamp_flag_exp = 1'b1;
`else
        clamp_exp      = 16'h0500;
        clamp_flag_exp = 1'b0;
`endif
        send_word(16'h0500);
        wait_tick();
        chk("clamp_pos", 32'(newPos), 32'(clamp_exp));
        chk("clamp_flag", 32'(clamp_hit), 32'(clamp_flag_exp));
        pulse_clr();
        chk("clr_all_flags", {29'd0, overflow, underrun, clamp_hit}, 32'd0);

        // Reset with 5 words queued and a high byte pending
        for (int i = 0; i < 5; i++) send_word(16'h3000 + 16'(i));
        send_byte(8'h77);
        chk("prerst_level", 32'(fifo_level), 32'd5);
        RST_N = 1'b0;
        #1;
        chk("midrst_clock_4ms", 32'(clock_4ms), 32'd0);
        chk("midrst_newPos", 32'(newPos), 32'd0);
        chk("midrst_sig", 32'(newPosSignal), 32'd0);
        chk("midrst_level", 32'(fifo_level), 32'd0);
        chk("midrst_flags", {29'd0, overflow, underrun, clamp_hit}, 32'd0);
        repeat (3) step();
        RST_N = 1'b1;
        cyc   = 0;
        send_byte(8'h88);
        step();
        chk("postrst_partial_dropped", 32'(fifo_level), 32'd0);
        wait_tick();
        chk("postrst_tick_cycle", 32'(cyc), 32'(TD));
        chk("postrst_sig", 32'(newPosSignal), 32'd0);
        chk("postrst_pos", 32'(newPos), 32'd0);
        chk("postrst_underrun", 32'(underrun), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
